// File: rtl/mips_defs_pkg.sv
// Shared MIPS decode constants: opcodes, instruction field positions and
// the immediate-extension classification used by the decode stage.
package mips_defs_pkg;

  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI  = 6'h0F;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam int DEFAULT_LINK_REG = 31;

  typedef enum logic [1:0] {
    IMM_SIGN  = 2'd0,
    IMM_ZERO  = 2'd1,
    IMM_UPPER = 2'd2
  } imm_kind_e;

  // Logical immediates are unsigned; LUI arrives already shifted into the upper half.
  function automatic imm_kind_e imm_kind(input logic [5:0] opcode);
    imm_kind_e kind;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: kind = IMM_ZERO;
      OP_LUI:                   kind = IMM_UPPER;
      default:                  kind = IMM_SIGN;
    endcase
    return kind;
  endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational read ports, one synchronous
// write port, hard-wired zero register and optional same-cycle write bypass.
module reg_file
  import mips_defs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter int BYPASS_EN = 1,
  localparam int ADDR_W   = $clog2(REG_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data
);

  if ((1 << ADDR_W) != REG_N) begin : g_reg_n_check
    $error("reg_file: REG_N must be a power of two");
  end

  logic [DATA_W-1:0] regs [REG_N];
  logic              wr_live;

  assign wr_live = wr_en && (wr_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_live) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    if (rs_addr == '0) begin
      rs_data = '0;
    end else if ((BYPASS_EN != 0) && wr_live && (wr_addr == rs_addr)) begin
      rs_data = wr_data;
    end else begin
      rs_data = regs[rs_addr];
    end
  end

  always_comb begin
    if (rt_addr == '0) begin
      rt_data = '0;
    end else if ((BYPASS_EN != 0) && wr_live && (wr_addr == rt_addr)) begin
      rt_data = wr_data;
    end else begin
      rt_data = regs[rt_addr];
    end
  end

endmodule

// File: rtl/decode_regfile_pipe.sv
// Decode stage: write-back muxing into the register file, immediate
// extension and the ID/EX pipeline register with flush/stall control.
module decode_regfile_pipe
  import mips_defs_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_N     = 32,
  parameter int LINK_REG  = DEFAULT_LINK_REG,
  parameter int BYPASS_EN = 1,
  localparam int ADDR_W   = $clog2(REG_N)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       instr_in,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_en,
  input  logic              wb_jal,
  input  logic              wb_mem_to_reg,
  input  logic              wb_reg_dst,
  input  logic [ADDR_W-1:0] wb_rt,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_pc_plus4,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_rs_data,
  output logic [DATA_W-1:0] id_rt_data,
  output logic [DATA_W-1:0] id_imme,
  output logic [ADDR_W-1:0] id_rs,
  output logic [ADDR_W-1:0] id_rt,
  output logic [ADDR_W-1:0] id_rd,
  output logic [5:0]        id_opcode,
  output logic [5:0]        id_funct
);

  if (DATA_W < 32) begin : g_data_w_check
    $error("decode_regfile_pipe: DATA_W must be at least 32");
  end

  logic [5:0]        dec_opcode;
  logic [5:0]        dec_funct;
  logic [ADDR_W-1:0] dec_rs;
  logic [ADDR_W-1:0] dec_rt;
  logic [ADDR_W-1:0] dec_rd;
  logic [15:0]       dec_imm16;
  logic [DATA_W-1:0] dec_imme;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  assign dec_opcode = instr_in[OP_MSB:OP_LSB];
  assign dec_funct  = instr_in[FUNCT_MSB:FUNCT_LSB];
  assign dec_rs     = instr_in[RS_LSB +: ADDR_W];
  assign dec_rt     = instr_in[RT_LSB +: ADDR_W];
  assign dec_rd     = instr_in[RD_LSB +: ADDR_W];
  assign dec_imm16  = instr_in[IMM_MSB:IMM_LSB];

  // A jal link overrides both the destination and source selects.
  always_comb begin
    if (wb_jal) begin
      wb_addr = ADDR_W'(LINK_REG);
    end else if (wb_reg_dst) begin
      wb_addr = wb_rd;
    end else begin
      wb_addr = wb_rt;
    end
  end

  always_comb begin
    if (wb_jal) begin
      wb_data = wb_pc_plus4;
    end else if (wb_mem_to_reg) begin
      wb_data = mem_data;
    end else begin
      wb_data = alu_result;
    end
  end

  // Widths beyond 32 bits keep the same rule: LUI's 32-bit result is sign-extended.
  always_comb begin
    case (imm_kind(dec_opcode))
      IMM_ZERO:  dec_imme = DATA_W'(dec_imm16);
      IMM_UPPER: dec_imme = DATA_W'($signed({dec_imm16, 16'h0000}));
      default:   dec_imme = DATA_W'($signed(dec_imm16));
    endcase
  end

  reg_file #(
    .DATA_W    (DATA_W),
    .REG_N     (REG_N),
    .BYPASS_EN (BYPASS_EN)
  ) u_reg_file (
    .clock   (clock),
    .reset   (reset),
    .rs_addr (dec_rs),
    .rt_addr (dec_rt),
    .wr_en   (wb_en),
    .wr_addr (wb_addr),
    .wr_data (wb_data),
    .rs_data (rs_data),
    .rt_data (rt_data)
  );

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      id_valid   <= 1'b0;
      id_rs_data <= '0;
      id_rt_data <= '0;
      id_imme    <= '0;
      id_rs      <= '0;
      id_rt      <= '0;
      id_rd      <= '0;
      id_opcode  <= '0;
      id_funct   <= '0;
    end else if (!stall) begin
      id_valid   <= instr_valid;
      id_rs_data <= rs_data;
      id_rt_data <= rt_data;
      id_imme    <= dec_imme;
      id_rs      <= dec_rs;
      id_rt      <= dec_rt;
      id_rd      <= dec_rd;
      id_opcode  <= dec_opcode;
      id_funct   <= dec_funct;
    end
  end

endmodule

// File: tb/tb_decode_regfile_pipe.sv
// Self-checking bench for decode_regfile_pipe with a behavioural reference model.
module tb_decode_regfile_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] instr_in;
  logic        instr_valid, stall, flush;
  logic        wb_en, wb_jal, wb_mem_to_reg, wb_reg_dst;
  logic [4:0]  wb_rt, wb_rd;
  logic [31:0] alu_result, mem_data, wb_pc_plus4;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imme;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [5:0]  id_opcode, id_funct;

  int errors = 0;
  int checks = 0;

  logic [31:0] mregs [32];
  logic        e_valid;
  logic [31:0] e_rs_data, e_rt_data, e_imme;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [5:0]  e_opcode, e_funct;

  decode_regfile_pipe dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .instr_valid(instr_valid),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_jal(wb_jal),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_dst(wb_reg_dst), .wb_rt(wb_rt), .wb_rd(wb_rd),
    .alu_result(alu_result), .mem_data(mem_data), .wb_pc_plus4(wb_pc_plus4),
    .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imme(id_imme),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_opcode(id_opcode), .id_funct(id_funct)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    int unsigned imm;
    imm = ins[15:0];
    case (ins[31:26])
      6'h0C, 6'h0D, 6'h0E: return imm;
      6'h0F:               return imm * 65536;
      default:             return (imm >= 32768) ? imm + 32'hFFFF0000 : imm;
    endcase
  endfunction

  // Reference behaviour for one rising edge, then step to just after that edge.
  task automatic apply_edge();
    int          wa;
    logic [31:0] wd;
    bit          wr;
    int          rs, rt;
    logic [31:0] rsv, rtv;
    wa = wb_jal ? 31 : (wb_reg_dst ? int'(wb_rd) : int'(wb_rt));
    wd = wb_jal ? wb_pc_plus4 : (wb_mem_to_reg ? mem_data : alu_result);
    wr = wb_en && (wa != 0);
    rs = instr_in[25:21];
    rt = instr_in[20:16];
    rsv = (rs == 0) ? 32'd0 : ((wr && wa == rs) ? wd : mregs[rs]);
    rtv = (rt == 0) ? 32'd0 : ((wr && wa == rt) ? wd : mregs[rt]);
    if (reset || flush) begin
      e_valid = 0; e_rs_data = 0; e_rt_data = 0; e_imme = 0;
      e_rs = 0; e_rt = 0; e_rd = 0; e_opcode = 0; e_funct = 0;
    end else if (!stall) begin
      e_valid = instr_valid; e_rs_data = rsv; e_rt_data = rtv; e_imme = ref_imm(instr_in);
      e_rs = 5'(rs); e_rt = 5'(rt); e_rd = instr_in[15:11];
      e_opcode = instr_in[31:26]; e_funct = instr_in[5:0];
    end
    if (reset) begin
      for (int i = 0; i < 32; i++) mregs[i] = 0;
    end else if (wr) begin
      mregs[wa] = wd;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic wb_idle();
    wb_en = 0; wb_jal = 0; wb_mem_to_reg = 0; wb_reg_dst = 0;
    wb_rt = 0; wb_rd = 0; alu_result = 0; mem_data = 0; wb_pc_plus4 = 0;
  endtask

  task automatic test_reset();
    reset = 1; instr_in = 32'hFFFF_FFFF; instr_valid = 1; stall = 0; flush = 0;
    wb_idle();
    apply_edge();
    apply_edge();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0h want=0", id_valid); end
    checks++; if ({id_rs_data, id_rt_data, id_imme} !== 96'd0) begin errors++; $display("FAIL reset_data got=%0h %0h %0h want=0", id_rs_data, id_rt_data, id_imme); end
    checks++; if ({id_rs, id_rt, id_rd, id_opcode, id_funct} !== 27'd0) begin errors++; $display("FAIL reset_fields got=%0h want=0", {id_rs, id_rt, id_rd, id_opcode, id_funct}); end
    reset = 0;
    instr_in = 32'h00A63020;
    apply_edge();
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%0h want=1", id_valid); end
    checks++; if (id_rs_data !== 32'd0 || id_rt_data !== 32'd0) begin errors++; $display("FAIL first_read got=%0h %0h want=0 0", id_rs_data, id_rt_data); end
    checks++; if (id_rs !== 5'd5 || id_rt !== 5'd6 || id_rd !== 5'd6 || id_funct !== 6'h20) begin
      errors++; $display("FAIL first_fields got rs=%0d rt=%0d rd=%0d fn=%0h want 5 6 6 20", id_rs, id_rt, id_rd, id_funct); end
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_reg_dst = 1; wb_rd = 8; alu_result = 32'h12345678; mem_data = 32'h0BAD0BAD;
    instr_in = mk_r(8, 0, 9, 32'h20);
    apply_edge();
    checks++; if (id_rs_data !== 32'h12345678) begin errors++; $display("FAIL bypass_rs got=%0h want=12345678", id_rs_data); end
    wb_idle();
    instr_in = mk_r(0, 8, 9, 32'h20);
    apply_edge();
    checks++; if (id_rt_data !== 32'h12345678) begin errors++; $display("FAIL stored_rt got=%0h want=12345678", id_rt_data); end
    wb_en = 1; wb_rt = 10; wb_rd = 11; wb_mem_to_reg = 1; mem_data = 32'hCAFEF00D; alu_result = 32'h11;
    instr_in = mk_r(10, 10, 0, 0);
    apply_edge();
    checks++; if (id_rs_data !== 32'hCAFEF00D || id_rt_data !== 32'hCAFEF00D) begin
      errors++; $display("FAIL mem_to_rt got=%0h %0h want=cafef00d", id_rs_data, id_rt_data); end
    wb_idle();
  endtask

  task automatic test_link_and_r0();
    wb_en = 1; wb_jal = 1; wb_pc_plus4 = 32'h00400010; wb_mem_to_reg = 1; wb_reg_dst = 1;
    wb_rd = 9; wb_rt = 10; mem_data = 32'hDEADBEEF; alu_result = 32'h5;
    instr_in = mk_r(31, 9, 0, 0);
    apply_edge();
    checks++; if (id_rs_data !== 32'h00400010 || id_rt_data !== 32'd0) begin
      errors++; $display("FAIL jal_bypass got=%0h %0h want=00400010 0", id_rs_data, id_rt_data); end
    wb_idle();
    instr_in = mk_r(31, 9, 0, 0);
    apply_edge();
    checks++; if (id_rs_data !== 32'h00400010 || id_rt_data !== 32'd0) begin
      errors++; $display("FAIL jal_stored got=%0h %0h want=00400010 0", id_rs_data, id_rt_data); end
    instr_in = mk_r(10, 0, 0, 0);
    apply_edge();
    checks++; if (id_rs_data !== 32'hCAFEF00D) begin errors++; $display("FAIL jal_rt_untouched got=%0h want=cafef00d", id_rs_data); end
    wb_en = 1; wb_reg_dst = 1; wb_rd = 0; alu_result = 32'hFFFFFFFF;
    instr_in = mk_r(0, 0, 0, 0);
    apply_edge();
    checks++; if (id_rs_data !== 32'd0 || id_rt_data !== 32'd0) begin
      errors++; $display("FAIL r0_bypass got=%0h %0h want=0 0", id_rs_data, id_rt_data); end
    wb_idle();
    apply_edge();
    checks++; if (id_rs_data !== 32'd0) begin errors++; $display("FAIL r0_stored got=%0h want=0", id_rs_data); end
  endtask

  task automatic test_imm();
    logic [31:0] ins [6];
    logic [31:0] want [6];
    ins[0] = mk_i(6'h0D, 0, 1, 16'h8001); want[0] = 32'h00008001;
    ins[1] = mk_i(6'h08, 0, 1, 16'h8001); want[1] = 32'hFFFF8001;
    ins[2] = mk_i(6'h0F, 0, 1, 16'h1234); want[2] = 32'h12340000;
    ins[3] = mk_i(6'h0C, 0, 1, 16'hFFFF); want[3] = 32'h0000FFFF;
    ins[4] = mk_i(6'h0E, 0, 1, 16'h9000); want[4] = 32'h00009000;
    ins[5] = mk_i(6'h23, 0, 1, 16'h7FFF); want[5] = 32'h00007FFF;
    for (int i = 0; i < 6; i++) begin
      instr_in = ins[i];
      apply_edge();
      checks++; if (id_imme !== want[i]) begin errors++; $display("FAIL imm_%0d got=%0h want=%0h", i, id_imme, want[i]); end
    end
  endtask

  task automatic test_stall_flush();
    instr_in = mk_i(6'h08, 8, 11, 16'h0042);
    instr_valid = 1;
    apply_edge();
    for (int c = 0; c < 3; c++) begin
      stall = 1;
      instr_in = $urandom;
      instr_valid = 1'($urandom);
      if (c == 1) begin wb_en = 1; wb_rd = 12; wb_reg_dst = 1; alu_result = 32'h0BADC0DE; end
      else wb_idle();
      apply_edge();
      checks++; if (id_valid !== 1'b1 || id_rs_data !== 32'h12345678 || id_imme !== 32'h42 ||
                    id_rt !== 5'd11 || id_opcode !== 6'h08) begin
        errors++; $display("FAIL stall_hold_%0d got v=%0h rs=%0h imm=%0h rt=%0d op=%0h", c, id_valid, id_rs_data, id_imme, id_rt, id_opcode); end
    end
    wb_idle();
    stall = 0; instr_valid = 1;
    instr_in = mk_r(12, 8, 3, 6'h21);
    apply_edge();
    checks++; if (id_rs_data !== 32'h0BADC0DE) begin errors++; $display("FAIL write_during_stall got=%0h want=0badc0de", id_rs_data); end
    stall = 1; flush = 1;
    apply_edge();
    checks++; if (id_valid !== 1'b0 || id_rs_data !== 32'd0 || id_rt_data !== 32'd0 || id_rs !== 5'd0) begin
      errors++; $display("FAIL flush_over_stall got v=%0h rs=%0h rt=%0h", id_valid, id_rs_data, id_rt_data); end
    stall = 0; flush = 0;
    instr_valid = 0;
    instr_in = mk_r(12, 0, 0, 0);
    apply_edge();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL invalid_instr got=%0h want=0", id_valid); end
    instr_valid = 1;
  endtask

  task automatic test_reset_mid();
    instr_in = mk_r(31, 12, 4, 6'h22);
    apply_edge();
    stall = 1; reset = 1;
    apply_edge();
    checks++; if (id_valid !== 1'b0 || {id_rs_data, id_rt_data, id_imme} !== 96'd0 ||
                  {id_rs, id_rt, id_rd, id_opcode, id_funct} !== 27'd0) begin
      errors++; $display("FAIL reset_mid_stall got v=%0h rs=%0h rt=%0h", id_valid, id_rs_data, id_rt_data); end
    reset = 0; stall = 0;
    for (int r = 1; r < 32; r += 2) begin
      instr_in = mk_r(r, r + 1 < 32 ? r + 1 : 0, 0, 0);
      apply_edge();
      checks++; if (id_rs_data !== 32'd0 || id_rt_data !== 32'd0) begin
        errors++; $display("FAIL regs_cleared_r%0d got=%0h %0h want=0 0", r, id_rs_data, id_rt_data); end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [9];
    ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h03, 6'h04};
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(99) < 2);
      stall = ($urandom_range(99) < 20);
      flush = ($urandom_range(99) < 10);
      instr_valid = ($urandom_range(99) < 85);
      instr_in = {ops[$urandom_range(8)], 26'($urandom)};
      wb_en = ($urandom_range(99) < 70);
      wb_jal = ($urandom_range(99) < 15);
      wb_mem_to_reg = 1'($urandom);
      wb_reg_dst = 1'($urandom);
      wb_rt = 5'($urandom); wb_rd = 5'($urandom);
      alu_result = $urandom; mem_data = $urandom; wb_pc_plus4 = $urandom;
      apply_edge();
      checks++; if (id_valid !== e_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%0h want=%0h", n, id_valid, e_valid); end
      checks++; if (id_rs_data !== e_rs_data) begin errors++; $display("FAIL rnd_rs_data n=%0d got=%0h want=%0h", n, id_rs_data, e_rs_data); end
      checks++; if (id_rt_data !== e_rt_data) begin errors++; $display("FAIL rnd_rt_data n=%0d got=%0h want=%0h", n, id_rt_data, e_rt_data); end
      checks++; if (id_imme !== e_imme) begin errors++; $display("FAIL rnd_imme n=%0d got=%0h want=%0h", n, id_imme, e_imme); end
      checks++; if ({id_rs, id_rt, id_rd} !== {e_rs, e_rt, e_rd}) begin
        errors++; $display("FAIL rnd_regs n=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", n, id_rs, id_rt, id_rd, e_rs, e_rt, e_rd); end
      checks++; if ({id_opcode, id_funct} !== {e_opcode, e_funct}) begin
        errors++; $display("FAIL rnd_op n=%0d got=%0h/%0h want=%0h/%0h", n, id_opcode, id_funct, e_opcode, e_funct); end
    end
    reset = 0; stall = 0; flush = 0;
    wb_idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = 0;
    test_reset();
    test_bypass();
    test_link_and_r0();
    test_imm();
    test_stall_flush();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode_regfile_pipe.md
Name: decode_regfile_pipe

Overview:
- Parametrised successor to the single-cycle decode stage: register file, write-back mux, immediate extension and an ID/EX pipeline register with stall/flush control.
- Sits between instruction fetch and the ALU/execute stage of the pipelined MIPS core.
- Write-back inputs come from the WB stage.
- Same-cycle write/read is bypassed, so no separate register-file forwarding is needed.

Parameters:
- DATA_W, 32, datapath and register width
- REG_N, 32, number of architectural registers; must be a power of two
- ADDR_W, $clog2(REG_N), register index width (derived, not overridable)
- LINK_REG, 31, destination register for jal link writes
- BYPASS_EN, 1, when 1 a same-cycle WB write to a read register is forwarded to the read data

Ports:
- clock  input  1  system clock, all state updates on the rising edge
- reset  input  1  synchronous, active-high; clears all state
- instr_in  input  32  instruction from IF
- instr_valid  input  1  instr_in holds a real instruction
- stall  input  1  hold the ID/EX register
- flush  input  1  squash the ID/EX register (branch taken or jump)
- wb_en  input  1  write-back enable (RegWrite)
- wb_jal  input  1  write-back is a jal link
- wb_mem_to_reg  input  1  write-back source: 1 = mem_data, 0 = alu_result
- wb_reg_dst  input  1  write-back destination: 1 = wb_rd, 0 = wb_rt
- wb_rt  input  ADDR_W  rt field of the WB instruction
- wb_rd  input  ADDR_W  rd field of the WB instruction
- alu_result  input  DATA_W  ALU result at WB
- mem_data  input  DATA_W  load data at WB
- wb_pc_plus4  input  DATA_W  link value for jal
- id_valid  output  1  ID/EX slot valid
- id_rs_data  output  DATA_W  read data for rs
- id_rt_data  output  DATA_W  read data for rt
- id_imme  output  DATA_W  extended immediate
- id_rs, id_rt, id_rd  output  ADDR_W each  register fields, passed on for the hazard unit
- id_opcode  output  6  opcode
- id_funct  output  6  funct field

Behaviour:
- Reset: all REG_N registers become 0.
- Reset: id_valid = 0; every ID/EX output = 0.
- Write-back address:
  - wb_jal = 1: LINK_REG.
  - else wb_reg_dst = 1: wb_rd.
  - else: wb_rt.
- Write-back data:
  - wb_jal = 1: wb_pc_plus4.
  - else wb_mem_to_reg = 1: mem_data.
  - else: alu_result.
- wb_jal takes priority over both wb_reg_dst and wb_mem_to_reg.
- Register write: on a rising edge when wb_en = 1 and the write address != 0.
- Register 0 always reads 0; writes to it are dropped.
- Register reads are combinational from instr_in[25:21] (rs) and [20:16] (rt).
- Bypass: if BYPASS_EN = 1, wb_en = 1, the write address is nonzero and it equals a read index, that read returns the write-back data in the same cycle.
- Immediate extension:
  - Opcodes ANDI (0x0C), ORI (0x0D), XORI (0x0E): zero-extend instr_in[15:0].
  - LUI (0x0F): {imm, 16'b0}, passed through pre-shifted.
  - All other opcodes: sign-extend.
  - When DATA_W > 32, extend to DATA_W using the same rule.
- ID/EX register update on each rising edge, highest priority first:
  1. reset → cleared.
  2. flush → id_valid <= 0 and data outputs <= 0; flush wins over stall.
  3. stall → all outputs hold.
  4. otherwise → load decoded values; id_valid <= instr_valid.
- Latency: 1 cycle from instr_in to the id_* outputs. Register-file write takes effect at the edge after wb_en.
- Simultaneous write and stall: the register file still writes. Held outputs are not refreshed, because the hazard unit re-stalls on a RAW dependency.
- Reset asserted mid-stall or mid-flush: reset wins and everything clears that edge.
- instr_valid = 0 with no stall/flush: id_valid <= 0; data fields are still loaded and are don't-care.

Decomposition:
- Package mips_defs_pkg holds:
  - Opcode constants OP_ANDI, OP_ORI, OP_XORI, OP_LUI, OP_JAL.
  - Field position constants RS_MSB/LSB, RT_MSB/LSB, RD_MSB/LSB.
  - Default LINK_REG.
- One sub-module, reg_file (parameters DATA_W, REG_N, BYPASS_EN):
  - Two combinational read ports, one synchronous write port, zero-register rule and bypass.
- The top level holds the write-back muxes, immediate extender and ID/EX register.

Test Plan:
1. Reset, then read r5/r6 via instr 0x00A63020 → next cycle id_rs_data = 0, id_rt_data = 0, id_valid = 1.
2. wb_en = 1, wb_reg_dst = 1, wb_rd = 8, alu_result = 0x12345678, while instr reads rs = 8 the same cycle → id_rs_data = 0x12345678 (bypass); after write, BYPASS_EN = 0 build shows the old value that cycle.
3. wb_jal = 1, wb_pc_plus4 = 0x00400010, wb_mem_to_reg = 1, wb_reg_dst = 1 → r31 = 0x00400010 and rd untouched; write wb_rd = 0 with 0xFFFFFFFF → r0 still reads 0.
4. Immediates:
   - ORI imm 0x8001 → id_imme = 0x00008001.
   - ADDI imm 0x8001 → 0xFFFF8001.
   - LUI imm 0x1234 → 0x12340000.
5. Load instr A, assert stall 3 cycles while instr_in changes → outputs hold A. Assert stall and flush together → id_valid = 0 next cycle.
6. Assert reset mid-stream with stall = 1 → id_valid = 0, all outputs 0, all registers read 0 afterwards.
